// File: rtl/mem_arbiter_pkg.sv
// Shared AXI4-Lite constants and the address-window helpers used by mem_arbiter.
package axi4;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [2:0] PROT_PRIVILEGED  = 3'b001;
   localparam logic [2:0] PROT_NONSECURE   = 3'b010;
   localparam logic [2:0] PROT_INSTRUCTION = 3'b100;

   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
      return (addr & ~(size - 32'd1)) == base;
   endfunction

   function automatic logic [31:0] window_offset(input logic [31:0] addr,
                                                 input logic [31:0] size);
      return addr & (size - 32'd1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arbiter (
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] grant
);

   // 1 = data (req[1]) was granted last, so fetch (req[0]) is favoured.
   logic last_data;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_data ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         last_data <= 1'b1;
      end else if (adv && (grant != 2'b00)) begin
         last_data <= grant[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data AXI4-Lite read arbiter and data write forwarder onto one memory port,
// answering accesses outside [BASE, BASE+SIZE) locally with DECERR.
//
// state | meaning
// RIDLE | waiting for a read request; grant issued combinationally
// RADDR | offset address presented on mem AR channel
// RRESP | mem R channel routed to the granted requester
// RERR  | out-of-window read answered locally with DECERR
// WIDLE | waiting for data awvalid and wvalid together
// WREQ  | mem AW and W presented, each retired on its own handshake
// WRESP | mem B channel passed through to data
// WERR  | out-of-window write answered locally with DECERR
module mem_arbiter
   import axi4::*;
#(
   parameter logic [31:0] BASE = 32'h0000_0000,
   parameter logic [31:0] SIZE = 32'h0000_1000
) (
   input  logic        aclk,
   input  logic        aresetn,

   input  logic [31:0] fetch_araddr,
   input  logic [2:0]  fetch_arprot,
   input  logic        fetch_arvalid,
   output logic        fetch_arready,
   output logic [31:0] fetch_rdata,
   output logic [1:0]  fetch_rresp,
   output logic        fetch_rvalid,
   input  logic        fetch_rready,
   input  logic [31:0] fetch_awaddr,
   input  logic [2:0]  fetch_awprot,
   input  logic        fetch_awvalid,
   output logic        fetch_awready,
   input  logic [31:0] fetch_wdata,
   input  logic [3:0]  fetch_wstrb,
   input  logic        fetch_wvalid,
   output logic        fetch_wready,
   output logic [1:0]  fetch_bresp,
   output logic        fetch_bvalid,
   input  logic        fetch_bready,

   input  logic [31:0] data_araddr,
   input  logic [2:0]  data_arprot,
   input  logic        data_arvalid,
   output logic        data_arready,
   output logic [31:0] data_rdata,
   output logic [1:0]  data_rresp,
   output logic        data_rvalid,
   input  logic        data_rready,
   input  logic [31:0] data_awaddr,
   input  logic [2:0]  data_awprot,
   input  logic        data_awvalid,
   output logic        data_awready,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
   input  logic        data_wvalid,
   output logic        data_wready,
   output logic [1:0]  data_bresp,
   output logic        data_bvalid,
   input  logic        data_bready,

   output logic [31:0] mem_araddr,
   output logic [2:0]  mem_arprot,
   output logic        mem_arvalid,
   input  logic        mem_arready,
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  mem_rresp,
   input  logic        mem_rvalid,
   output logic        mem_rready,
   output logic [31:0] mem_awaddr,
   output logic [2:0]  mem_awprot,
   output logic        mem_awvalid,
   input  logic        mem_awready,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        mem_wvalid,
   input  logic        mem_wready,
   input  logic [1:0]  mem_bresp,
   input  logic        mem_bvalid,
   output logic        mem_bready
);

   typedef enum logic [1:0] {RIDLE, RADDR, RRESP, RERR} rstate_t;
   typedef enum logic [1:0] {WIDLE, WREQ, WRESP, WERR} wstate_t;

   rstate_t     rstate;
   wstate_t     wstate;
   logic        rwin;
   logic [1:0]  rreq;
   logic [1:0]  rgrant;
   logic [31:0] gaddr;
   logic [2:0]  gprot;
   logic        win_rready;
   logic        rd_rvalid;
   logic [31:0] rd_rdata;
   logic [1:0]  rd_rresp;
   logic        wgo;
   logic        aw_done;
   logic        w_done;

   // Fetch never writes; its write channels are accepted nowhere.
   logic unused_fetch_wr;
   assign unused_fetch_wr = ^{fetch_awaddr, fetch_awprot, fetch_awvalid, fetch_wdata,
                              fetch_wstrb, fetch_wvalid, fetch_bready};
   assign fetch_awready = 1'b0;
   assign fetch_wready  = 1'b0;
   assign fetch_bvalid  = 1'b0;
   assign fetch_bresp   = OKAY;

   // Gating with aresetn keeps every ready low while reset is held.
   assign rreq = {data_arvalid, fetch_arvalid} & {2{(rstate == RIDLE) && aresetn}};

   rr_arbiter u_rr (
      .clk_sys (aclk),
      .rst_b   (aresetn),
      .req     (rreq),
      .adv     (rstate == RIDLE),
      .grant   (rgrant)
   );

   assign fetch_arready = rgrant[0];
   assign data_arready  = rgrant[1];
   assign gaddr = rgrant[1] ? data_araddr : fetch_araddr;
   assign gprot = rgrant[1] ? data_arprot : fetch_arprot;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rstate      <= RIDLE;
         rwin        <= 1'b0;
         mem_araddr  <= 32'h0;
         mem_arprot  <= 3'b000;
         mem_arvalid <= 1'b0;
      end else begin
         case (rstate)
            RIDLE: begin
               if (rgrant != 2'b00) begin
                  rwin       <= rgrant[1];
                  mem_araddr <= window_offset(gaddr, SIZE);
                  mem_arprot <= gprot;
                  if (in_window(gaddr, BASE, SIZE)) begin
                     rstate      <= RADDR;
                     mem_arvalid <= 1'b1;
                  end else begin
                     rstate <= RERR;
                  end
               end
            end
            RADDR: begin
               if (mem_arready) begin
                  mem_arvalid <= 1'b0;
                  rstate      <= RRESP;
               end
            end
            RRESP: begin
               if (mem_rvalid && win_rready) rstate <= RIDLE;
            end
            RERR: begin
               if (win_rready) rstate <= RIDLE;
            end
            default: rstate <= RIDLE;
         endcase
      end
   end

   assign win_rready = rwin ? data_rready : fetch_rready;
   assign mem_rready = (rstate == RRESP) && win_rready;
   assign rd_rvalid  = ((rstate == RRESP) && mem_rvalid) || (rstate == RERR);
   assign rd_rdata   = (rstate == RRESP) ? mem_rdata : 32'h0;
   assign rd_rresp   = (rstate == RERR) ? DECERR : mem_rresp;

   // Only the winner sees the response; the other requester's R channel stays quiet.
   assign fetch_rvalid = rd_rvalid && !rwin;
   assign fetch_rdata  = rwin ? 32'h0 : rd_rdata;
   assign fetch_rresp  = rwin ? OKAY : rd_rresp;
   assign data_rvalid  = rd_rvalid && rwin;
   assign data_rdata   = rwin ? rd_rdata : 32'h0;
   assign data_rresp   = rwin ? rd_rresp : OKAY;

   assign wgo          = (wstate == WIDLE) && aresetn && data_awvalid && data_wvalid;
   assign data_awready = wgo;
   assign data_wready  = wgo;
   assign aw_done      = !mem_awvalid || mem_awready;
   assign w_done       = !mem_wvalid || mem_wready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wstate      <= WIDLE;
         mem_awaddr  <= 32'h0;
         mem_awprot  <= 3'b000;
         mem_wdata   <= 32'h0;
         mem_wstrb   <= 4'h0;
         mem_awvalid <= 1'b0;
         mem_wvalid  <= 1'b0;
      end else begin
         case (wstate)
            WIDLE: begin
               if (wgo) begin
                  mem_awaddr <= window_offset(data_awaddr, SIZE);
                  mem_awprot <= data_awprot;
                  mem_wdata  <= data_wdata;
                  mem_wstrb  <= data_wstrb;
                  if (in_window(data_awaddr, BASE, SIZE)) begin
                     wstate      <= WREQ;
                     mem_awvalid <= 1'b1;
                     mem_wvalid  <= 1'b1;
                  end else begin
                     wstate <= WERR;
                  end
               end
            end
            WREQ: begin
               if (mem_awvalid && mem_awready) mem_awvalid <= 1'b0;
               if (mem_wvalid && mem_wready)   mem_wvalid  <= 1'b0;
               if (aw_done && w_done)          wstate      <= WRESP;
            end
            WRESP: begin
               if (mem_bvalid && data_bready) wstate <= WIDLE;
            end
            WERR: begin
               if (data_bready) wstate <= WIDLE;
            end
            default: wstate <= WIDLE;
         endcase
      end
   end

   assign data_bvalid = ((wstate == WRESP) && mem_bvalid) || (wstate == WERR);
   assign data_bresp  = (wstate == WERR) ? DECERR : mem_bresp;
   assign mem_bready  = (wstate == WRESP) && data_bready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays both requesters and memory.
module tb_mem_arbiter;
   import axi4::*;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] fetch_araddr, fetch_rdata, fetch_awaddr, fetch_wdata;
   logic [2:0]  fetch_arprot, fetch_awprot;
   logic [1:0]  fetch_rresp, fetch_bresp;
   logic [3:0]  fetch_wstrb;
   logic        fetch_arvalid, fetch_arready, fetch_rvalid, fetch_rready;
   logic        fetch_awvalid, fetch_awready, fetch_wvalid, fetch_wready;
   logic        fetch_bvalid, fetch_bready;
   logic [31:0] data_araddr, data_rdata, data_awaddr, data_wdata;
   logic [2:0]  data_arprot, data_awprot;
   logic [1:0]  data_rresp, data_bresp;
   logic [3:0]  data_wstrb;
   logic        data_arvalid, data_arready, data_rvalid, data_rready;
   logic        data_awvalid, data_awready, data_wvalid, data_wready;
   logic        data_bvalid, data_bready;
   logic [31:0] mem_araddr, mem_rdata, mem_awaddr, mem_wdata;
   logic [2:0]  mem_arprot, mem_awprot;
   logic [1:0]  mem_rresp, mem_bresp;
   logic [3:0]  mem_wstrb;
   logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
   logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready;
   logic        mem_bvalid, mem_bready;

   int tests = 0;
   int fails = 0;

   always #5 aclk = ~aclk;

   mem_arbiter dut (
      .aclk(aclk), .aresetn(aresetn),
      .fetch_araddr(fetch_araddr), .fetch_arprot(fetch_arprot), .fetch_arvalid(fetch_arvalid),
      .fetch_arready(fetch_arready), .fetch_rdata(fetch_rdata), .fetch_rresp(fetch_rresp),
      .fetch_rvalid(fetch_rvalid), .fetch_rready(fetch_rready), .fetch_awaddr(fetch_awaddr),
      .fetch_awprot(fetch_awprot), .fetch_awvalid(fetch_awvalid), .fetch_awready(fetch_awready),
      .fetch_wdata(fetch_wdata), .fetch_wstrb(fetch_wstrb), .fetch_wvalid(fetch_wvalid),
      .fetch_wready(fetch_wready), .fetch_bresp(fetch_bresp), .fetch_bvalid(fetch_bvalid),
      .fetch_bready(fetch_bready),
      .data_araddr(data_araddr), .data_arprot(data_arprot), .data_arvalid(data_arvalid),
      .data_arready(data_arready), .data_rdata(data_rdata), .data_rresp(data_rresp),
      .data_rvalid(data_rvalid), .data_rready(data_rready), .data_awaddr(data_awaddr),
      .data_awprot(data_awprot), .data_awvalid(data_awvalid), .data_awready(data_awready),
      .data_wdata(data_wdata), .data_wstrb(data_wstrb), .data_wvalid(data_wvalid),
      .data_wready(data_wready), .data_bresp(data_bresp), .data_bvalid(data_bvalid),
      .data_bready(data_bready),
      .mem_araddr(mem_araddr), .mem_arprot(mem_arprot), .mem_arvalid(mem_arvalid),
      .mem_arready(mem_arready), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
      .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_awaddr(mem_awaddr),
      .mem_awprot(mem_awprot), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid),
      .mem_wready(mem_wready), .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid),
      .mem_bready(mem_bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // Single in-window read by one requester (who: 0=fetch, 1=data), issued from RIDLE.
   task automatic rd_single(input logic who, input logic [31:0] addr, input logic [31:0] rd);
      if (who) begin data_arvalid = 1'b1; data_araddr = addr; end
      else begin fetch_arvalid = 1'b1; fetch_araddr = addr; end
      #1;
      chk("rd_fetch_arready", fetch_arready, !who);
      chk("rd_data_arready", data_arready, who);
      step();
      fetch_arvalid = 1'b0; data_arvalid = 1'b0;
      #1;
      chk("rd_mem_arvalid", mem_arvalid, 1);
      chk("rd_mem_araddr", mem_araddr, addr & 32'h0000_0FFF);
      chk("rd_arready_released", fetch_arready | data_arready, 0);
      mem_arready = 1'b1;
      step();
      mem_arready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = rd; mem_rresp = OKAY;
      fetch_rready = 1'b1; data_rready = 1'b1;
      #1;
      chk("rd_winner_rvalid", who ? data_rvalid : fetch_rvalid, 1);
      chk("rd_loser_rvalid", who ? fetch_rvalid : data_rvalid, 0);
      chk("rd_rdata", who ? data_rdata : fetch_rdata, rd);
      chk("rd_rresp", who ? data_rresp : fetch_rresp, OKAY);
      chk("rd_mem_rready", mem_rready, 1);
      step();
      mem_rvalid = 1'b0; fetch_rready = 1'b0; data_rready = 1'b0;
      #1;
      chk("rd_rvalid_done", fetch_rvalid | data_rvalid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      aresetn = 1'b0;
      fetch_araddr = 0; fetch_arprot = PROT_INSTRUCTION; fetch_arvalid = 0; fetch_rready = 0;
      fetch_awaddr = 0; fetch_awprot = 0; fetch_awvalid = 0; fetch_wdata = 0; fetch_wstrb = 0;
      fetch_wvalid = 0; fetch_bready = 0;
      data_araddr = 0; data_arprot = PROT_PRIVILEGED; data_arvalid = 0; data_rready = 0;
      data_awaddr = 0; data_awprot = PROT_NONSECURE; data_awvalid = 0; data_wdata = 0;
      data_wstrb = 0; data_wvalid = 0; data_bready = 0;
      mem_arready = 0; mem_rdata = 0; mem_rresp = 0; mem_rvalid = 0;
      mem_awready = 0; mem_wready = 0; mem_bresp = 0; mem_bvalid = 0;

      step();
      chk("reset_mem_arvalid", mem_arvalid, 0);
      chk("reset_mem_awvalid", mem_awvalid, 0);
      chk("reset_fetch_rvalid", fetch_rvalid, 0);
      chk("reset_data_bvalid", data_bvalid, 0);
      aresetn = 1'b1;
      step();

      // Lone fetch read, in window.
      rd_single(1'b0, 32'h0000_0010, 32'h1234_5678);
      chk("fetch_tieoff_awready", fetch_awready, 0);

      // Fresh reset, then both requesters contend: F, D, F, D.
      aresetn = 1'b0;
      step();
      aresetn = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         fetch_arvalid = 1'b1; fetch_araddr = 32'h0000_0100;
         data_arvalid = 1'b1;  data_araddr = 32'h0000_0200;
         #1;
         chk("rr_fetch_arready", fetch_arready, (i % 2) == 0);
         chk("rr_data_arready", data_arready, (i % 2) == 1);
         step();
         if ((i % 2) == 0) fetch_arvalid = 1'b0; else data_arvalid = 1'b0;
         #1;
         chk("rr_mem_araddr", mem_araddr, ((i % 2) == 0) ? 32'h100 : 32'h200);
         chk("rr_loser_arready", fetch_arready | data_arready, 0);
         mem_arready = 1'b1;
         step();
         mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + i;
         fetch_rready = 1'b1; data_rready = 1'b1;
         #1;
         chk("rr_fetch_rvalid", fetch_rvalid, (i % 2) == 0);
         chk("rr_data_rvalid", data_rvalid, (i % 2) == 1);
         step();
         mem_rvalid = 1'b0; fetch_rready = 1'b0; data_rready = 1'b0;
      end
      fetch_arvalid = 1'b0; data_arvalid = 1'b0;
      step();

      // Out-of-window data read answered locally.
      data_arvalid = 1'b1; data_araddr = 32'h0000_2000;
      #1;
      chk("decerr_arready", data_arready, 1);
      step();
      data_arvalid = 1'b0;
      #1;
      chk("decerr_mem_arvalid", mem_arvalid, 0);
      chk("decerr_rvalid", data_rvalid, 1);
      chk("decerr_rresp", data_rresp, DECERR);
      chk("decerr_rdata", data_rdata, 0);
      step();
      chk("decerr_rvalid_held", data_rvalid, 1);
      data_rready = 1'b1;
      step();
      data_rready = 1'b0;
      #1;
      chk("decerr_rvalid_done", data_rvalid, 0);
      chk("decerr_mem_arvalid_end", mem_arvalid, 0);

      // Write at the top of the window with a slow AW handshake.
      data_awvalid = 1'b1; data_wvalid = 1'b1; data_awaddr = 32'h0000_0FFC;
      data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b1100;
      #1;
      chk("wr_awready", data_awready, 1);
      chk("wr_wready", data_wready, 1);
      step();
      data_awvalid = 1'b0; data_wvalid = 1'b0;
      #1;
      chk("wr_mem_awvalid", mem_awvalid, 1);
      chk("wr_mem_wvalid", mem_wvalid, 1);
      chk("wr_mem_awaddr", mem_awaddr, 32'h0000_0FFC);
      chk("wr_mem_wstrb", mem_wstrb, 4'b1100);
      chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("wr_mem_awprot", mem_awprot, PROT_NONSECURE);
      mem_wready = 1'b1;
      step();
      mem_wready = 1'b0;
      #1;
      chk("wr_w_dropped", mem_wvalid, 0);
      chk("wr_aw_held", mem_awvalid, 1);
      step();
      step();
      chk("wr_aw_held2", mem_awvalid, 1);
      chk("wr_no_early_bvalid", data_bvalid, 0);
      mem_awready = 1'b1;
      step();
      mem_awready = 1'b0;
      #1;
      chk("wr_aw_dropped", mem_awvalid, 0);
      chk("wr_bvalid_wait", data_bvalid, 0);
      data_bready = 1'b1;
      step();
      mem_bvalid = 1'b1; mem_bresp = OKAY;
      #1;
      chk("wr_bvalid", data_bvalid, 1);
      chk("wr_bresp", data_bresp, OKAY);
      chk("wr_mem_bready", mem_bready, 1);
      step();
      mem_bvalid = 1'b0; data_bready = 1'b0;
      #1;
      chk("wr_bvalid_done", data_bvalid, 0);

      // Concurrent data write and fetch read.
      data_awvalid = 1'b1; data_wvalid = 1'b1; data_awaddr = 32'h0000_0020;
      data_wdata = 32'h5555_AAAA; data_wstrb = 4'hF;
      fetch_arvalid = 1'b1; fetch_araddr = 32'h0000_0040;
      #1;
      chk("cc_awready", data_awready, 1);
      chk("cc_arready", fetch_arready, 1);
      step();
      data_awvalid = 1'b0; data_wvalid = 1'b0; fetch_arvalid = 1'b0;
      #1;
      chk("cc_overlap", {mem_arvalid, mem_awvalid, mem_wvalid}, 3'b111);
      chk("cc_mem_arprot", mem_arprot, PROT_INSTRUCTION);
      mem_arready = 1'b1; mem_awready = 1'b1; mem_wready = 1'b1;
      step();
      mem_arready = 1'b0; mem_awready = 1'b0; mem_wready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0040; mem_bvalid = 1'b1;
      fetch_rready = 1'b1; data_bready = 1'b1;
      #1;
      chk("cc_fetch_rvalid", fetch_rvalid, 1);
      chk("cc_fetch_rdata", fetch_rdata, 32'hCAFE_0040);
      chk("cc_data_bvalid", data_bvalid, 1);
      step();
      mem_rvalid = 1'b0; mem_bvalid = 1'b0; fetch_rready = 1'b0; data_bready = 1'b0;
      #1;
      chk("cc_done", {fetch_rvalid, data_bvalid}, 2'b00);

      // Reset while a fetch read sits in RRESP.
      fetch_arvalid = 1'b1; fetch_araddr = 32'h0000_0080;
      step();
      fetch_arvalid = 1'b0; mem_arready = 1'b1;
      step();
      mem_arready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
      #1;
      chk("rst_pre_rvalid", fetch_rvalid, 1);
      aresetn = 1'b0;
      #1;
      chk("rst_async_rvalid", fetch_rvalid, 0);
      chk("rst_async_mem_rready", mem_rready, 0);
      chk("rst_async_mem_arvalid", mem_arvalid, 0);
      step();
      aresetn = 1'b1;
      step();
      chk("rst_stale_rvalid", fetch_rvalid, 0);
      mem_rvalid = 1'b0;
      rd_single(1'b0, 32'h0000_0030, 32'h7777_0030);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
